i2c_slave_regfile: RTL and testbench
====================================

Name: i2c_slave_regfile

Overview:
Parametrised I2C slave with an internal byte register file and an auto-incrementing register pointer. It is the successor to the fixed-address single-byte I2C_slave. It supports multi-byte writes and reads, repeated START, and host-side access to the register file. It sits behind the IOBUF pad wrapper, with the SCL/SDA inputs and SDA drive/enable feeding the open-drain pad.

Parameters:
SLAVE_ADDR, 7'h53, 7-bit device address matched on the bus
NUM_REGS, 16, register count; power of two, 2..256
SYNC_STAGES, 2, synchroniser depth on SCL_i/SDA_i (>=2)
PTR_W, $clog2(NUM_REGS), derived pointer width (localparam)

Ports:
clk  in  1  system clock; must be at least 8x the SCL rate
rstn  in  1  asynchronous active-low reset
SCL_i  in  1  bus clock from pad
SDA_i  in  1  bus data from pad
SDA_in_en  out  1  1 = SDA released (input); 0 = slave drives SDA_o
SDA_o  out  1  value driven when SDA_in_en=0 (always 0 for ACK/data-0)
host_addr  in  PTR_W  host read address into register file
host_rdata  out  8  combinational read of reg[host_addr]
wr_valid  out  1  one-clk pulse per I2C data byte written
wr_addr  out  PTR_W  register written (valid with wr_valid)
wr_data  out  8  byte written (valid with wr_valid)
busy  out  1  high between an addressed START and STOP
gc_hit  out  1  one-clk pulse when general call is ACKed (0 if feature off)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rstn).
- Reset values:
  - SDA_in_en=1, SDA_o=1, busy=0, wr_valid=0, gc_hit=0, wr_addr=0, wr_data=0.
  - Pointer=0; all registers=8'h00; FSM=IDLE.
- Input conditioning:
  - SCL_i/SDA_i pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised values.
  - Event latency from pin change = SYNC_STAGES+1 clk.
- Bus conditions:
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
  - START or STOP is recognised in any state and takes priority over bit processing in the same clk.
- Bit timing:
  - SDA is sampled on SCL rising.
  - SDA_in_en/SDA_o change only on the clk after SCL falling.
  - A bit counter (0..7) shifts MSB first.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - If [7:1]==SLAVE_ADDR, go to ADDR_ACK and drive 0 for one SCL period.
    - On mismatch, release SDA and return to IDLE (ignore the rest until the next START).
  - ADDR_ACK: RW=0 -> PTR; RW=1 -> RDATA, loading the shift register with reg[ptr].
  - PTR: shift 8 bits; ptr <= byte[PTR_W-1:0] (upper bits ignored); ACK; -> WDATA.
  - WDATA: shift 8 bits; on the 8th SCL rise, write reg[ptr], pulse wr_valid; ACK; ptr <= ptr+1 mod NUM_REGS; stay in WDATA.
  - RDATA: drive bits MSB first; release SDA during the master ACK bit (RACK).
    - Master ACK=0: ptr+1 mod NUM_REGS, reload, continue.
    - Master NACK=1: release SDA, go to IDLE-wait (STOP/START only).
- Pointer and repeated START:
  - The pointer persists across transactions.
  - A repeated START after the PTR write, followed by addr+R, reads from the new pointer.
- Wrap: ptr at NUM_REGS-1 increments to 0 on both read and write.
- busy: set on address match, cleared on STOP or on a START that then mismatches.
- Abort conditions:
  - STOP mid-byte discards the partial byte (no write, no pulse) and releases SDA.
  - rstn asserted mid-transfer immediately releases SDA and clears state.
- Host access:
  - host_rdata is an async read.
  - Simultaneous host read and I2C write to the same reg returns the old value that clk.

Optional Feature:
- I2C_GENERAL_CALL_EN defined:
  - Address byte 8'h00 is ACKed and gc_hit pulses.
  - The following bytes behave exactly as the PTR/WDATA write path.
  - General call with RW=1 is NACKed (released).
- Undefined: 8'h00 is treated as a mismatch and gc_hit is tied 0.

Decomposition:
- Package i2c_pkg: FSM state enum, START/STOP event type, ACK/NACK constants (ACK=1'b0).
- Sub-module i2c_bus_sync: synchroniser plus SCL rise/fall and START/STOP detection, parametrised by SYNC_STAGES.
- The FSM and register file stay in the top module.

Test Plan:
- Write 0x53+W, ptr 0x03, data 0xA5,0x5A, STOP -> 4 ACKs; wr_valid at addr 3 (0xA5) and 4 (0x5A); host_addr=4 gives host_rdata=0x5A.
- Write ptr 0x02, repeated START, 0x53+R, master ACK then NACK -> slave returns reg[2], reg[3]; ptr ends at 4; SDA released after NACK.
- Address 0x52+W -> no ACK (SDA_in_en=1 throughout); busy=0; no wr_valid.
- NUM_REGS=16, ptr 0x0F, write 3 bytes -> writes land at 15, 0, 1 (wrap).
- STOP after 5 bits of a data byte -> no wr_valid, busy=0; the next transaction is ACKed normally.
- With I2C_GENERAL_CALL_EN: address 0x00+W -> ACK, gc_hit pulse, ptr/data write as normal. Without the macro -> NACK, gc_hit=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave register file: FSM states, bus events and
// the ACK/NACK bus levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_START,
    EV_STOP
  } bus_ev_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with SCL edge and START/STOP detection. Every output is
// registered, so an event appears SYNC_STAGES+1 clocks after the pin change.
module i2c_bus_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    scl_pin,
  input  logic    sda_pin,
  output logic    scl_rise,
  output logic    scl_fall,
  output logic    sda_smp,
  output bus_ev_e bus_ev
);

  logic [SYNC_STAGES-1:0] scl_p0, sda_p0;
  logic                   scl_p1, sda_p1;
  logic                   scl_s, sda_s;

  assign scl_s = scl_p0[SYNC_STAGES-1];
  assign sda_s = sda_p0[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_p0   <= '1;
      sda_p0   <= '1;
      scl_p1   <= 1'b1;
      sda_p1   <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      sda_smp  <= 1'b1;
      bus_ev   <= EV_NONE;
    end else begin
      scl_p0   <= {scl_p0[SYNC_STAGES-2:0], scl_pin};
      sda_p0   <= {sda_p0[SYNC_STAGES-2:0], sda_pin};
      // stage boundary: synchronised level -> previous level and event flags
      scl_p1   <= scl_s;
      sda_p1   <= sda_s;
      scl_rise <= scl_s & ~scl_p1;
      scl_fall <= ~scl_s & scl_p1;
      sda_smp  <= sda_s;
      if (scl_s && scl_p1 && sda_p1 && !sda_s)
        bus_ev <= EV_START;
      else if (scl_s && scl_p1 && !sda_p1 && sda_s)
        bus_ev <= EV_STOP;
      else
        bus_ev <= EV_NONE;
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave with a byte register file and auto-incrementing pointer.
// Optional: define I2C_GENERAL_CALL_EN to ACK the general-call address 8'h00.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h53,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PTR_W       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             SCL_i,
  input  logic             SDA_i,
  output logic             SDA_in_en,
  output logic             SDA_o,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy,
  output logic             gc_hit
);

`ifdef I2C_GENERAL_CALL_EN
  localparam logic GC_EN = 1'b1;
`else
  localparam logic GC_EN = 1'b0;
`endif

  logic    scl_rise, scl_fall, sda;
  bus_ev_e bus_ev;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .scl_pin  (SCL_i),
    .sda_pin  (SDA_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_smp  (sda),
    .bus_ev   (bus_ev)
  );

  state_e           state_q, state_n;
  logic [2:0]       bit_cnt_q, bit_cnt_n;
  logic [7:0]       shreg_q, shreg_n;
  logic [PTR_W-1:0] ptr_q, ptr_n;
  logic             ack_drv_q, ack_drv_n;
  logic             rw_q, rw_n;
  logic             sda_rel_q, sda_rel_n;
  logic             busy_n, wr_valid_n, gc_hit_n;
  logic [PTR_W-1:0] wr_addr_n;
  logic [7:0]       wr_data_n;
  logic [7:0]       byte_in, rd_byte;
  logic             gc_ok;
  logic [7:0]       regs [NUM_REGS];

  assign byte_in    = {shreg_q[6:0], sda};
  assign rd_byte    = regs[ptr_q];
  assign gc_ok      = GC_EN && (byte_in == 8'h00);
  assign host_rdata = regs[host_addr];
  assign SDA_in_en  = sda_rel_q;
  assign SDA_o      = sda_rel_q;

  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    shreg_n    = shreg_q;
    ptr_n      = ptr_q;
    ack_drv_n  = ack_drv_q;
    rw_n       = rw_q;
    sda_rel_n  = sda_rel_q;
    busy_n     = busy;
    wr_valid_n = 1'b0;
    gc_hit_n   = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;

    if (bus_ev == EV_STOP) begin
      state_n   = ST_IDLE;
      sda_rel_n = 1'b1;
      busy_n    = 1'b0;
      bit_cnt_n = 3'd0;
      ack_drv_n = 1'b0;
    end else if (bus_ev == EV_START) begin
      state_n   = ST_ADDR;
      sda_rel_n = 1'b1;
      bit_cnt_n = 3'd0;
      ack_drv_n = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_ADDR) begin
                if (byte_in[7:1] == SLAVE_ADDR || gc_ok) begin
                  state_n  = ST_ADDR_ACK;
                  rw_n     = byte_in[0];
                  busy_n   = 1'b1;
                  gc_hit_n = gc_ok;
                end else begin
                  state_n = ST_IDLE;
                  busy_n  = 1'b0;
                end
              end else if (state_q == ST_PTR) begin
                ptr_n   = byte_in[PTR_W-1:0];
                state_n = ST_PTR_ACK;
              end else begin
                wr_valid_n = 1'b1;
                wr_addr_n  = ptr_q;
                wr_data_n  = byte_in;
                ptr_n      = ptr_q + PTR_W'(1);
                state_n    = ST_WDATA_ACK;
              end
            end
          end
        end

        // First SCL fall after the byte starts the ACK, the next one ends it.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_rel_n = ACK;
              ack_drv_n = 1'b1;
            end else begin
              ack_drv_n = 1'b0;
              bit_cnt_n = 3'd0;
              sda_rel_n = 1'b1;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                state_n   = ST_RDATA;
                shreg_n   = rd_byte;
                sda_rel_n = rd_byte[7];
              end else if (state_q == ST_ADDR_ACK) begin
                state_n = ST_PTR;
              end else begin
                state_n = ST_WDATA;
              end
            end
          end
        end

        // bit_cnt counts rises already sampled by the master; wraps to 0 after 8.
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt_q + 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              state_n   = ST_RACK;
              sda_rel_n = 1'b1;
              ack_drv_n = 1'b0;
            end else begin
              sda_rel_n = shreg_q[3'd7 - bit_cnt_q];
            end
          end
        end

        ST_RACK: begin
          if (scl_rise) begin
            ptr_n = ptr_q + PTR_W'(1);
            if (sda == NACK)
              state_n = ST_IDLE;
            else
              ack_drv_n = 1'b1;
          end else if (scl_fall && ack_drv_q) begin
            ack_drv_n = 1'b0;
            state_n   = ST_RDATA;
            shreg_n   = rd_byte;
            sda_rel_n = rd_byte[7];
            bit_cnt_n = 3'd0;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'h00;
      ptr_q     <= '0;
      ack_drv_q <= 1'b0;
      rw_q      <= 1'b0;
      sda_rel_q <= 1'b1;
      busy      <= 1'b0;
      wr_valid  <= 1'b0;
      gc_hit    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
    end else begin
      state_q   <= state_n;
      bit_cnt_q <= bit_cnt_n;
      shreg_q   <= shreg_n;
      ptr_q     <= ptr_n;
      ack_drv_q <= ack_drv_n;
      rw_q      <= rw_n;
      sda_rel_q <= sda_rel_n;
      busy      <= busy_n;
      wr_valid  <= wr_valid_n;
      gc_hit    <= gc_hit_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else if (wr_valid_n) begin
      regs[wr_addr_n] <= wr_data_n;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, register-file model and
// a per-cycle compare process for write pulses and host reads.
module tb_i2c_slave_regfile;

  localparam int Q = 5;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] host_addr = 4'd0;
  logic       SDA_in_en, SDA_o, wr_valid, busy, gc_hit;
  logic [3:0] wr_addr;
  logic [7:0] host_rdata, wr_data;
  wire        sda_bus = sda_m & (SDA_in_en | SDA_o);

  always #5 clk = ~clk;

  i2c_slave_regfile dut (
    .clk        (clk),
    .rstn       (rstn),
    .SCL_i      (scl_m),
    .SDA_i      (sda_bus),
    .SDA_in_en  (SDA_in_en),
    .SDA_o      (SDA_o),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .gc_hit     (gc_hit)
  );

  int         n_pass = 0;
  int         n_tot = 0;
  int         drive_cnt = 0;
  int         gc_cnt = 0;
  int         model_ptr = 0;
  logic [7:0] model_regs [16];
  wr_t        exp_q [$];
  logic [7:0] tx_q [$];
  logic [7:0] rd_log [$];
  logic       last_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Compare process: write pulses against the scoreboard, host reads against the model.
  initial begin
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rstn) begin
        if (wr_valid) begin
          chk("wr_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
            model_regs[e.addr] = e.data;
          end
        end
        chk("host_rdata", host_rdata, model_regs[host_addr]);
        if (!SDA_in_en) begin
          chk("sda_o_low_when_driving", SDA_o, 0);
          drive_cnt++;
        end
        if (gc_hit) gc_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b;
    host_addr = 4'($urandom);
    wait_q();
    scl_m = 1'b1;
    wait_q();
    r = sda_bus;
    last_en = SDA_in_en;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic start_cond();
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic stop_cond();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b1;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    acked = (r == 1'b0);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic mack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      b[i] = r;
    end
    bit_xfer(!mack, r);
  endtask

  task automatic do_write(input logic [7:0] p);
    logic       a;
    logic [7:0] d;
    wr_t        e;
    start_cond();
    write_byte(8'hA6, a);
    chk("addr_w_ack", a, 1);
    chk("busy_set", busy, 1);
    write_byte(p, a);
    chk("ptr_ack", a, 1);
    model_ptr = p % 16;
    while (tx_q.size() > 0) begin
      d = tx_q.pop_front();
      e.addr = 4'(model_ptr);
      e.data = d;
      exp_q.push_back(e);
      write_byte(d, a);
      chk("data_ack", a, 1);
      model_ptr = (model_ptr + 1) % 16;
    end
    stop_cond();
    repeat (8) @(negedge clk);
    chk("busy_clr", busy, 0);
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n);
    logic       a;
    logic [7:0] b;
    start_cond();
    if (set_ptr) begin
      write_byte(8'hA6, a);
      chk("addr_w_ack", a, 1);
      write_byte(p, a);
      chk("ptr_ack", a, 1);
      model_ptr = p % 16;
      start_cond();
    end
    write_byte(8'hA7, a);
    chk("addr_r_ack", a, 1);
    for (int k = 0; k < n; k++) begin
      read_byte(b, k < n - 1);
      chk("rdata", b, model_regs[model_ptr]);
      chk("rack_released", last_en, 1);
      rd_log.push_back(b);
      model_ptr = (model_ptr + 1) % 16;
    end
    chk("released_after_nack", SDA_in_en, 1);
    stop_cond();
    repeat (8) @(negedge clk);
    chk("busy_clr", busy, 0);
  endtask

  task automatic host_chk(input string nm, input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk);
    host_addr = a;
    #1;
    chk(nm, host_rdata, exp);
  endtask

  initial begin
    logic       a, r;
    int         dc, gcb, kind, n;
    repeat (3) @(negedge clk);
    chk("rst_sda_in_en", SDA_in_en, 1);
    chk("rst_sda_o", SDA_o, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_gc_hit", gc_hit, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_host_rdata", host_rdata, 0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);

    // Two-byte write at pointer 3
    tx_q = '{8'hA5, 8'h5A};
    do_write(8'h03);
    host_chk("lit_reg4", 4'd4, 8'h5A);
    host_chk("lit_reg3", 4'd3, 8'hA5);

    // Pointer write, repeated START, two-byte read, then continue from pointer
    rd_log.delete();
    do_read(1'b1, 8'h02, 2);
    do_read(1'b0, 8'h00, 1);
    chk("lit_read_reg2", rd_log[0], 8'h00);
    chk("lit_read_reg3", rd_log[1], 8'hA5);
    chk("lit_ptr_end4", rd_log[2], 8'h5A);

    // Foreign address
    dc = drive_cnt;
    start_cond();
    write_byte(8'hA4, a);
    chk("mismatch_nack", a, 0);
    chk("mismatch_busy", busy, 0);
    write_byte(8'h11, a);
    stop_cond();
    repeat (8) @(negedge clk);
    chk("mismatch_no_drive", drive_cnt - dc, 0);

    // Pointer wrap
    tx_q = '{8'hC1, 8'hC2, 8'hC3};
    do_write(8'h0F);
    host_chk("lit_wrap15", 4'd15, 8'hC1);
    host_chk("lit_wrap0", 4'd0, 8'hC2);
    host_chk("lit_wrap1", 4'd1, 8'hC3);

    // STOP after five data bits
    start_cond();
    write_byte(8'hA6, a);
    chk("abort_addr_ack", a, 1);
    write_byte(8'h08, a);
    chk("abort_ptr_ack", a, 1);
    model_ptr = 8;
    for (int i = 0; i < 5; i++) bit_xfer(1'b1, r);
    stop_cond();
    repeat (8) @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_released", SDA_in_en, 1);
    tx_q = '{8'h77};
    do_write(8'h08);
    host_chk("lit_after_abort", 4'd8, 8'h77);

    // General call
    gcb = gc_cnt;
    start_cond();
    write_byte(8'h00, a);
`ifdef I2C_GENERAL_CALL_EN
    chk("gc_ack", a, 1);
    write_byte(8'h0A, a);
    chk("gc_ptr_ack", a, 1);
    begin
      wr_t e;
      e.addr = 4'hA;
      e.data = 8'h3C;
      exp_q.push_back(e);
    end
    write_byte(8'h3C, a);
    chk("gc_data_ack", a, 1);
    model_ptr = 11;
    stop_cond();
    repeat (8) @(negedge clk);
    chk("gc_pulses", gc_cnt - gcb, 1);
    host_chk("lit_gc_write", 4'hA, 8'h3C);
`else
    chk("gc_nack", a, 0);
    stop_cond();
    repeat (8) @(negedge clk);
    chk("gc_pulses", gc_cnt - gcb, 0);
`endif

    // Randomized traffic
    for (int t = 0; t < 25; t++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 4);
      if (kind == 0) begin
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
        do_write(8'($urandom));
      end else begin
        do_read(kind == 1, 8'($urandom), n);
      end
    end

    // Reset during an address ACK
    start_cond();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] ab;
      ab = 8'hA6;
      bit_xfer(ab[i], r);
    end
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    chk("ack_driving_before_rst", SDA_in_en, 0);
    rstn = 1'b0;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    exp_q.delete();
    model_ptr = 0;
    #1;
    chk("rst_mid_released", SDA_in_en, 1);
    chk("rst_mid_busy", busy, 0);
    sda_m = 1'b1;
    scl_m = 1'b1;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    host_chk("lit_regs_cleared", 4'd3, 8'h00);
    tx_q = '{8'h99};
    do_write(8'h05);
    rd_log.delete();
    do_read(1'b1, 8'h05, 1);
    chk("lit_after_reset_rw", rd_log[0], 8'h99);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
